traffic_light_controller_param: RTL and testbench



---
 rtl/traffic_light_controller_param.sv | 136 +++++++++++++
 tb/tb_traffic_light_controller_param.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_controller_param.sv
// Highway-priority traffic light FSM with cycle-count phase timers.
// Optional pedestrian walk phase enabled by defining PED_PHASE_EN.
module traffic_light_controller_param #(
  parameter int Y2R_CYCLES      = 3,
  parameter int R2G_CYCLES      = 2,
  parameter int MIN_GREEN       = 8,
  parameter int MAX_CNTRY_GREEN = 6,
  parameter int WALK_CYCLES     = 4,
  parameter int TIMER_W         = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       X,
  input  logic       ped_req,
  output logic [1:0] hwy,
  output logic [1:0] cntry,
  output logic       walk,
  output logic [2:0] state_o
);

  localparam logic [2:0] S_HGRN  = 3'd0;
  localparam logic [2:0] S_HYEL  = 3'd1;
  localparam logic [2:0] S_ARED1 = 3'd2;
  localparam logic [2:0] S_CGRN  = 3'd3;
  localparam logic [2:0] S_CYEL  = 3'd4;
  localparam logic [2:0] S_ARED2 = 3'd5;
  localparam logic [2:0] S_PWALK = 3'd6;

  localparam logic [1:0] L_RED = 2'd0;
  localparam logic [1:0] L_YEL = 2'd1;
  localparam logic [1:0] L_GRN = 2'd2;

  localparam logic [TIMER_W-1:0] Y2R_END  = TIMER_W'(Y2R_CYCLES - 1);
  localparam logic [TIMER_W-1:0] R2G_END  = TIMER_W'(R2G_CYCLES - 1);
  localparam logic [TIMER_W-1:0] MIN_END  = TIMER_W'(MIN_GREEN - 1);
  localparam logic [TIMER_W-1:0] CG_END   = TIMER_W'(MAX_CNTRY_GREEN - 1);
  localparam logic [TIMER_W-1:0] WALK_END = TIMER_W'(WALK_CYCLES - 1);

  logic [2:0]         state;
  logic [2:0]         state_nx;
  logic [TIMER_W-1:0] timer;
  logic               ped_pending;
  logic               ped_set;
  logic               ped_eff;

`ifdef PED_PHASE_EN
  assign ped_set = ped_req && (state != S_PWALK);
  // A request in the deciding cycle already counts for the S2 branch
  assign ped_eff = ped_pending | ped_set;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ped_pending <= 1'b0;
    end else if (state_nx == S_PWALK && state != S_PWALK) begin
      ped_pending <= 1'b0;
    end else if (ped_set) begin
      ped_pending <= 1'b1;
    end
  end
`else
  logic ped_unused;
  assign ped_unused  = ^{ped_req, WALK_END};
  assign ped_set     = 1'b0;
  assign ped_eff     = 1'b0;
  assign ped_pending = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_HGRN: begin
        if (timer >= MIN_END && (X || ped_pending))
          state_nx = S_HYEL;
      end
      S_HYEL: begin
        if (timer == Y2R_END)
          state_nx = S_ARED1;
      end
      S_ARED1: begin
        if (timer == R2G_END)
          state_nx = ped_eff ? S_PWALK : S_CGRN;
      end
      S_CGRN: begin
        if (!X || timer == CG_END)
          state_nx = S_CYEL;
      end
      S_CYEL: begin
        if (timer == Y2R_END)
          state_nx = S_ARED2;
      end
      S_ARED2: begin
        if (timer == R2G_END)
          state_nx = S_HGRN;
      end
`ifdef PED_PHASE_EN
      S_PWALK: begin
        if (timer == WALK_END)
          state_nx = X ? S_CGRN : S_ARED2;
      end
`endif
      default: state_nx = S_HGRN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_HGRN;
      timer <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state)
        timer <= '0;
      else if (timer != '1)
        timer <= timer + 1'b1;
    end
  end

  always_comb begin
    hwy   = L_RED;
    cntry = L_RED;
    walk  = 1'b0;
    case (state)
      S_HGRN: hwy   = L_GRN;
      S_HYEL: hwy   = L_YEL;
      S_CGRN: cntry = L_GRN;
      S_CYEL: cntry = L_YEL;
`ifdef PED_PHASE_EN
      S_PWALK: walk = 1'b1;
`endif
      default: ;
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_traffic_light_controller_param.sv
// Directed bench for traffic_light_controller_param.
// Covers both builds via PED_PHASE_EN.
module tb_traffic_light_controller_param;

  logic       clock;
  logic       reset;
  logic       X;
  logic       ped_req;
  logic [1:0] hwy;
  logic [1:0] cntry;
  logic       walk;
  logic [2:0] state_o;

  int errors;
  int checks;

  traffic_light_controller_param dut (
    .clock   (clock),
    .reset   (reset),
    .X       (X),
    .ped_req (ped_req),
    .hwy     (hwy),
    .cntry   (cntry),
    .walk    (walk),
    .state_o (state_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Counts negedges spent in state s, starting at the current negedge.
  task automatic dwell(input logic [2:0] s, output int n);
    n = 0;
    while (state_o == s && n < 200) begin
      n++;
      @(negedge clock);
    end
  endtask

  // Waits up to 200 negedges for state s; ok=0 on timeout.
  task automatic wait_state(input logic [2:0] s, output bit ok);
    int k;
    k = 0;
    while (state_o != s && k < 200) begin
      k++;
      @(negedge clock);
    end
    ok = (state_o == s);
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    X       = 1'b0;
    ped_req = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    int bad;
    reset   = 1'b0;
    X       = 1'b0;
    ped_req = 1'b0;
    repeat (5) @(negedge clock);
    checks++;
    if ({hwy, cntry, walk, state_o} !== {2'd2, 2'd0, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL reset_outputs: got hwy=%0d cntry=%0d walk=%0d st=%0d want 2 0 0 0",
               hwy, cntry, walk, state_o);
    end
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (hwy !== 2'd2 || cntry !== 2'd0 || state_o !== 3'd0)
        bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL idle_hold: got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_max_green();
    int  n;
    bit  ok;
    do_reset();
    X = 1'b1;
    dwell(3'd0, n);
    checks++;
    if (n !== 8) begin errors++; $display("FAIL s0_min_green: got %0d want 8", n); end
    dwell(3'd1, n);
    checks++;
    if (n !== 3) begin errors++; $display("FAIL s1_yellow: got %0d want 3", n); end
    dwell(3'd2, n);
    checks++;
    if (n !== 2) begin errors++; $display("FAIL s2_allred: got %0d want 2", n); end
    checks++;
    if (cntry !== 2'd2 || hwy !== 2'd0) begin
      errors++;
      $display("FAIL s3_lights: got hwy=%0d cntry=%0d want 0 2", hwy, cntry);
    end
    dwell(3'd3, n);
    checks++;
    if (n !== 6) begin errors++; $display("FAIL s3_max_green: got %0d want 6", n); end
    dwell(3'd4, n);
    checks++;
    if (n !== 3) begin errors++; $display("FAIL s4_yellow: got %0d want 3", n); end
    dwell(3'd5, n);
    checks++;
    if (n !== 2) begin errors++; $display("FAIL s5_allred: got %0d want 2", n); end
    dwell(3'd0, n);
    checks++;
    if (n !== 8) begin errors++; $display("FAIL s0_fairness: got %0d want 8", n); end
    checks++;
    if (state_o !== 3'd1) begin
      errors++;
      $display("FAIL s0_to_s1_again: got %0d want 1", state_o);
    end
    // asynchronous reset in the middle of a country phase
    wait_state(3'd3, ok);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (state_o !== 3'd0 || hwy !== 2'd2) begin
      errors++;
      $display("FAIL async_reset: got st=%0d hwy=%0d want 0 2", state_o, hwy);
    end
    @(negedge clock);
    reset = 1'b1;
    X     = 1'b0;
  endtask

  task automatic test_pulse_not_latched();
    int bad;
    do_reset();
    repeat (2) @(negedge clock);
    X = 1'b1;
    @(negedge clock);
    X = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (state_o !== 3'd0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL x_pulse_ignored: got %0d non-S0 cycles want 0", bad);
    end
  endtask

  task automatic test_early_release();
    int n;
    bit ok;
    do_reset();
    repeat (10) @(negedge clock);
    X = 1'b1;
    wait_state(3'd3, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reach_s3: got timeout want S3"); end
    @(negedge clock);
    @(negedge clock);
    X = 1'b0;
    checks++;
    if (state_o !== 3'd3) begin
      errors++;
      $display("FAIL s3_third_cycle: got %0d want 3", state_o);
    end
    @(negedge clock);
    checks++;
    if (state_o !== 3'd4 || cntry !== 2'd1) begin
      errors++;
      $display("FAIL s3_early_end: got st=%0d cntry=%0d want 4 1", state_o, cntry);
    end
    dwell(3'd4, n);
    checks++;
    if (n !== 3) begin errors++; $display("FAIL s4_after_early: got %0d want 3", n); end
    dwell(3'd5, n);
    checks++;
    if (n !== 2) begin errors++; $display("FAIL s5_after_early: got %0d want 2", n); end
    checks++;
    if (state_o !== 3'd0) begin
      errors++;
      $display("FAIL back_to_s0: got %0d want 0", state_o);
    end
  endtask

`ifdef PED_PHASE_EN
  task automatic test_ped_walk();
    int n;
    int bad;
    bit ok;
    do_reset();
    repeat (12) @(negedge clock);
    ped_req = 1'b1;
    @(negedge clock);
    ped_req = 1'b0;
    wait_state(3'd1, ok);
    dwell(3'd1, n);
    checks++;
    if (n !== 3) begin errors++; $display("FAIL ped_s1: got %0d want 3", n); end
    dwell(3'd2, n);
    checks++;
    if (n !== 2) begin errors++; $display("FAIL ped_s2: got %0d want 2", n); end
    checks++;
    if ({state_o, walk, hwy, cntry} !== {3'd6, 1'b1, 2'd0, 2'd0}) begin
      errors++;
      $display("FAIL ped_walk_lights: got st=%0d walk=%0d hwy=%0d cntry=%0d want 6 1 0 0",
               state_o, walk, hwy, cntry);
    end
    ped_req = 1'b1;
    @(negedge clock);
    ped_req = 1'b0;
    dwell(3'd6, n);
    checks++;
    if (n !== 3) begin errors++; $display("FAIL ped_s6: got %0d want 4", n + 1); end
    dwell(3'd5, n);
    checks++;
    if (n !== 2) begin errors++; $display("FAIL ped_s5: got %0d want 2", n); end
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (state_o !== 3'd0 || walk !== 1'b0) bad++;
      @(negedge clock);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL ped_no_second_walk: got %0d bad cycles want 0", bad);
    end
  endtask
`else
  task automatic test_ped_disabled();
    int bad;
    bit ok;
    do_reset();
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      ped_req = (i % 3 == 0);
      @(negedge clock);
      if (state_o !== 3'd0 || walk !== 1'b0) bad++;
    end
    ped_req = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL ped_ignored: got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_illegal_state();
    bit ok;
    do_reset();
    X = 1'b1;
    wait_state(3'd1, ok);
    X = 1'b0;
    force dut.state = 3'd7;
    @(negedge clock);
    release dut.state;
    @(negedge clock);
    checks++;
    if (state_o !== 3'd0 || hwy !== 2'd2) begin
      errors++;
      $display("FAIL illegal_recover: got st=%0d hwy=%0d want 0 2", state_o, hwy);
    end
  endtask
`endif

  initial begin
    errors  = 0;
    checks  = 0;
    reset   = 1'b0;
    X       = 1'b0;
    ped_req = 1'b0;
    test_reset();
    test_max_green();
    test_pulse_not_latched();
    test_early_release();
`ifdef PED_PHASE_EN
    test_ped_walk();
`else
    test_ped_disabled();
    test_illegal_state();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
